// File: rtl/jtag_dbgreg_pkg.sv
// Shared constants for the JTAG user-register engine.
// Bundle bit positions, select codes and default sizes.
package jtag_dbgreg_pkg;

  localparam logic DBG_SEL_ER1 = 1'b0;
  localparam logic DBG_SEL_ER2 = 1'b1;

  localparam int DBG_WIDTH = 32;
  localparam int DBG_SYNC  = 2;

  localparam int JB_TCK   = 0;
  localparam int JB_TDI   = 1;
  localparam int JB_SHIFT = 2;
  localparam int JB_UPD   = 3;
  localparam int JB_CE1   = 4;
  localparam int JB_CE2   = 5;
  localparam int JB_RSTN  = 6;
  localparam int JB_N     = 7;

endpackage

// File: rtl/jtag_sync.sv
// N-bit multi-stage synchroniser with an aligned output register
// and a registered rising-edge detect on bit 0.
module jtag_sync #(
  parameter int N      = 7,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         rise
);

  logic [N-1:0] chain [STAGES];
  logic         prev;

  // q and rise are registered together so data stays aligned with the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++)
        chain[i] <= '0;
      prev <= 1'b0;
      q    <= '0;
      rise <= 1'b0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++)
        chain[i] <= chain[i-1];
      prev <= chain[STAGES-1][0];
      q    <= chain[STAGES-1];
      rise <= chain[STAGES-1][0] & ~prev;
    end
  end

endmodule

// File: rtl/jtag_dbgreg.sv
// JTAG ER1/ER2 data-register engine: capture, shift and update
// in the clk domain, with TDO readout and an update strobe.
module jtag_dbgreg
  import jtag_dbgreg_pkg::*;
#(
  parameter int WIDTH       = DBG_WIDTH,
  parameter int SYNC_STAGES = DBG_SYNC,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jtck,
  input  logic             jtdi,
  input  logic             jshift,
  input  logic             jupdate,
  input  logic             jce1,
  input  logic             jce2,
  input  logic             jrstn,
  output logic             jtdo1,
  output logic             jtdo2,
  input  logic [WIDTH-1:0] dbgreg_in,
  output logic [WIDTH-1:0] dbgreg_out,
  output logic             dbgreg_sel,
  output logic             dbgreg_strobe,
  output logic [CNT_W-1:0] dbgreg_len
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [JB_N-1:0]  jin;
  logic [JB_N-1:0]  js;
  logic             tck_rise;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             sel;

  assign jin = {jrstn, jce2, jce1, jupdate,
                jshift, jtdi, jtck};

  jtag_sync #(
    .N      (JB_N),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (jin),
    .q    (js),
    .rise (tck_rise)
  );

  logic trst;
  logic go;
  logic do_upd;
  logic do_shf;
  logic do_cap;
  logic cap_sel;

  assign trst    = ~js[JB_RSTN];
  assign go      = tck_rise & js[JB_TCK];
  assign do_upd  = go & js[JB_UPD];
  assign do_shf  = go & ~js[JB_UPD] & js[JB_SHIFT];
  assign do_cap  = go & ~js[JB_UPD] & ~js[JB_SHIFT]
                 & (js[JB_CE1] | js[JB_CE2]);
  assign cap_sel = js[JB_CE2] ? DBG_SEL_ER2 : DBG_SEL_ER1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr            <= '0;
      cnt           <= '0;
      sel           <= DBG_SEL_ER1;
      jtdo1         <= 1'b0;
      jtdo2         <= 1'b0;
      dbgreg_out    <= '0;
      dbgreg_sel    <= DBG_SEL_ER1;
      dbgreg_len    <= '0;
      dbgreg_strobe <= 1'b0;
    end else begin
      dbgreg_strobe <= 1'b0;
      if (trst) begin
        sr    <= '0;
        cnt   <= '0;
        sel   <= DBG_SEL_ER1;
        jtdo1 <= 1'b0;
        jtdo2 <= 1'b0;
      end else begin
        unique case (1'b1)
          do_upd: begin
            dbgreg_out    <= sr;
            dbgreg_sel    <= sel;
            dbgreg_len    <= cnt;
            dbgreg_strobe <= 1'b1;
            cnt           <= '0;
          end
          do_shf: begin
            sr    <= {js[JB_TDI], sr[WIDTH-1:1]};
            cnt   <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            jtdo1 <= ~sel & sr[1];
            jtdo2 <= sel & sr[1];
          end
          do_cap: begin
            sr    <= dbgreg_in;
            cnt   <= '0;
            sel   <= cap_sel;
            jtdo1 <= ~cap_sel & dbgreg_in[0];
            jtdo2 <= cap_sel & dbgreg_in[0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_dbgreg.sv
// Scoreboard bench for jtag_dbgreg: directed JTAG transactions,
// expected strobes and TDO bits queued, checked by a monitor.
module tb_jtag_dbgreg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jtck = 1'b0, jtdi = 1'b0, jshift = 1'b0;
  logic        jupdate = 1'b0, jce1 = 1'b0, jce2 = 1'b0;
  logic        jrstn = 1'b1;
  logic        jtdo1, jtdo2;
  logic [31:0] dbgreg_in = '0;
  logic [31:0] dbgreg_out;
  logic        dbgreg_sel, dbgreg_strobe;
  logic [5:0]  dbgreg_len;

  always #10 clk = ~clk;

  jtag_dbgreg dut (
    .clk           (clk),
    .rst           (rst),
    .jtck          (jtck),
    .jtdi          (jtdi),
    .jshift        (jshift),
    .jupdate       (jupdate),
    .jce1          (jce1),
    .jce2          (jce2),
    .jrstn         (jrstn),
    .jtdo1         (jtdo1),
    .jtdo2         (jtdo2),
    .dbgreg_in     (dbgreg_in),
    .dbgreg_out    (dbgreg_out),
    .dbgreg_sel    (dbgreg_sel),
    .dbgreg_strobe (dbgreg_strobe),
    .dbgreg_len    (dbgreg_len)
  );

  typedef struct {
    logic [31:0] out;
    logic        sel;
    logic [5:0]  len;
    int          edge_c;
  } exp_t;

  exp_t        sbq[$];
  logic [1:0]  tdoq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        prev_stb = 1'b0;
  logic [31:0] exp_out;
  logic        exp_sel;
  logic [5:0]  exp_len;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (tdoq.size() > 0) begin
      logic [1:0] et;
      et = tdoq.pop_front();
      chk("tdo", {62'd0, jtdo2, jtdo1}, {62'd0, et});
    end
    if (dbgreg_strobe) begin
      chk("strobe_gap", {63'd0, prev_stb}, 64'd0);
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_strobe: got out=%h want no strobe",
                 dbgreg_out);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out", {32'd0, dbgreg_out}, {32'd0, e.out});
        chk("sel", {63'd0, dbgreg_sel}, {63'd0, e.sel});
        chk("len", {58'd0, dbgreg_len}, {58'd0, e.len});
        chk("latency", 64'(cyc - e.edge_c), 64'd3);
      end
    end
    prev_stb = dbgreg_strobe;
  end

  // one TCK period: low phase 4 clk with new controls, high phase 4 clk
  task automatic tck(input logic tdi, input logic shf,
                     input logic upd, input logic ce1,
                     input logic ce2, input logic rstn,
                     input bit stb);
    @(negedge clk);
    jtck = 1'b0; jtdi = tdi; jshift = shf; jupdate = upd;
    jce1 = ce1; jce2 = ce2; jrstn = rstn;
    repeat (3) @(negedge clk);
    jtck = 1'b1;
    if (stb)
      sbq.push_back('{exp_out, exp_sel, exp_len, cyc + 1});
    repeat (4) @(negedge clk);
  endtask

  task automatic txn(input logic ce1, input logic ce2,
                     input logic [31:0] din, input int nb,
                     input logic [127:0] data,
                     input logic [31:0] eo, input logic es,
                     input logic [5:0] el);
    dbgreg_in = din;
    tck(1'b0, 1'b0, 1'b0, ce1, ce2, 1'b1, 1'b0);
    for (int i = 0; i < nb; i++)
      tck(data[i], 1'b1, 1'b0, ce1, ce2, 1'b1, 1'b0);
    exp_out = eo; exp_sel = es; exp_len = el;
    tck(1'b0, 1'b0, 1'b1, ce1, ce2, 1'b1, 1'b1);
    tck(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_out"}, {32'd0, dbgreg_out}, 64'd0);
    chk({nm, "_sel"}, {63'd0, dbgreg_sel}, 64'd0);
    chk({nm, "_len"}, {58'd0, dbgreg_len}, 64'd0);
    chk({nm, "_stb"}, {63'd0, dbgreg_strobe}, 64'd0);
    chk({nm, "_tdo"}, {62'd0, jtdo2, jtdo1}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0]  rb;
    logic [127:0] d70;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    jrstn = 1'b0;
    repeat (6) @(negedge clk);
    jrstn = 1'b1;
    repeat (6) @(negedge clk);

    txn(1'b1, 1'b0, 32'h0, 32, 128'hDEADBEEF,
        32'hDEADBEEF, 1'b0, 6'd32);

    rb = 32'h12345678;
    dbgreg_in = rb;
    tck(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tdoq.push_back({rb[0], 1'b0});
    for (int i = 1; i <= 32; i++) begin
      tck(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tdoq.push_back({(i < 32) ? rb[i[4:0]] : 1'b0, 1'b0});
    end
    exp_out = 32'h0; exp_sel = 1'b1; exp_len = 6'd32;
    tck(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tck(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    txn(1'b1, 1'b0, 32'h0, 8, 128'hA5,
        32'hA5000000, 1'b0, 6'd8);
    txn(1'b1, 1'b0, 32'h0, 40, 128'h11CAFEF00D,
        32'h11CAFEF0, 1'b0, 6'd40);
    d70 = 128'h5A5A5A5A << 38;
    txn(1'b1, 1'b0, 32'h0, 70, d70,
        32'h5A5A5A5A, 1'b0, 6'd63);

    dbgreg_in = 32'hFFFFFFFF;
    tck(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      tck(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tdoq.push_back(2'b01);
    tck(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tdoq.push_back(2'b00);
    chk("trst_out", {32'd0, dbgreg_out}, 64'h5A5A5A5A);
    chk("trst_len", {58'd0, dbgreg_len}, 64'd63);
    txn(1'b1, 1'b0, 32'h0, 32, 128'h0BADF00D,
        32'h0BADF00D, 1'b0, 6'd32);

    txn(1'b1, 1'b1, 32'h0, 32, 128'h600DCAFE,
        32'h600DCAFE, 1'b1, 6'd32);

    dbgreg_in = 32'h0;
    tck(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++)
      tck(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    exp_out = 32'hFFFF0000; exp_sel = 1'b0; exp_len = 6'd16;
    tck(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    tck(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    txn(1'b1, 1'b0, 32'h0, 8, 128'hA5,
        32'hA5000000, 1'b0, 6'd8);
    dbgreg_in = 32'hFFFFFFFF;
    tck(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      tck(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    jtck = 1'b0;
    repeat (3) @(negedge clk);
    jtck = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_shift");
    jtck = 1'b0; jshift = 1'b0; jce1 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    txn(1'b1, 1'b0, 32'h0, 8, 128'hA5,
        32'hA5000000, 1'b0, 6'd8);
    dbgreg_in = 32'h0;
    tck(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      tck(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    jtck = 1'b0; jshift = 1'b0; jupdate = 1'b1;
    repeat (3) @(negedge clk);
    jtck = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    jtck = 1'b0; jupdate = 1'b0; jce1 = 1'b0;
    chk_zero("rst_pend");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    txn(1'b0, 1'b1, 32'h0, 32, 128'h13579BDF,
        32'h13579BDF, 1'b1, 6'd32);

    repeat (10) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("tdo_empty", 64'(tdoq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_dbgreg.md
Name: jtag_dbgreg

Overview:
- Clean JTAG user-register (ER1/ER2) data-register engine. Sits between the ECP5 JTAGG primitive and the soc debug-register interface (dbgreg_in/out/strobe/sel).
- Brings the TCK-domain JTAGG signals into the clk domain. Implements capture, shift and update of a WIDTH-bit DR, including TDO shift-out of the soc-supplied word.
- Delivers a one-cycle update strobe plus a shifted-bit count to the soc.

Parameters:
- WIDTH, 32, DR length in bits.
- SYNC_STAGES, 2, synchroniser flops per JTAG input (minimum 2).
- CNT_W, 6, width of the shifted-bit counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock (48 MHz). Must be at least 4x the TCK frequency.
- rst  in  1  synchronous, active-high reset.
- jtck  in  1  TCK from JTAGG, asynchronous.
- jtdi  in  1  TDI from JTAGG, asynchronous.
- jshift  in  1  JSHIFT, asynchronous.
- jupdate  in  1  JUPDATE, asynchronous.
- jce1  in  1  JCE1 (ER1 selected), asynchronous.
- jce2  in  1  JCE2 (ER2 selected), asynchronous.
- jrstn  in  1  JRSTN, TAP reset, active low, asynchronous.
- jtdo1  out  1  TDO for ER1.
- jtdo2  out  1  TDO for ER2.
- dbgreg_in  in  WIDTH  word captured for readout, from the soc.
- dbgreg_out  out  WIDTH  last updated DR value.
- dbgreg_sel  out  1  0 = ER1 (IR 0x32), 1 = ER2 (IR 0x38); valid with dbgreg_out.
- dbgreg_strobe  out  1  one-cycle pulse when dbgreg_out/sel/len are updated.
- dbgreg_len  out  CNT_W  number of bits shifted in the transaction just updated (saturating).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst). There are no other resets; jrstn is treated as data.
- Reset values: dbgreg_out=0, dbgreg_sel=0, dbgreg_strobe=0, dbgreg_len=0, jtdo1=jtdo2=0. The internal shift register, sel latch, counter and sync chains are all cleared.
- Synchronisation:
  - All seven JTAG inputs pass through SYNC_STAGES flops.
  - One extra flop on synced jtck forms the edge detector.
  - tck_rise = synced jtck high AND previous low.
  - Control and data bits are sampled from the same sync stage as jtck so they stay aligned.
- Latency: a jtck rising edge first sampled at clk edge k produces its register effects at edge k+SYNC_STAGES+1. With the default, dbgreg_strobe is high for exactly the cycle after edge k+3.
- TAP reset: synced jrstn low clears the shift register, counter and sel latch, and forces jtdo to 0. It has no effect on dbgreg_out, dbgreg_sel or dbgreg_len. No strobe is issued while jrstn is low.
- On tck_rise with jrstn high, exactly one of the following applies, in this priority order:
  - UPDATE (jupdate=1): dbgreg_out<=sr, dbgreg_sel<=sel, dbgreg_len<=cnt, dbgreg_strobe<=1 for one cycle, cnt<=0.
  - SHIFT (jshift=1):
    - sr<={jtdi, sr[WIDTH-1:1]} (LSB first, matching standard TDI order).
    - cnt<=cnt+1, saturating at 2^CNT_W-1.
    - Next jtdo value <= sr[1] (the bit about to reach position 0).
  - CAPTURE (jce1 or jce2, jshift=0):
    - sr<=dbgreg_in, cnt<=0.
    - sel<=jce2; if jce1 and jce2 are both high, sel=1.
    - jtdo<=dbgreg_in[0].
- TDO outputs:
  - jtdo1 = jtdo when sel=0, else 0.
  - jtdo2 = jtdo when sel=1, else 0.
  - Both are registered outputs.
- Shifting more than WIDTH bits: the oldest bits fall out of sr[0] and the last WIDTH bits are retained. dbgreg_len reports the true count up to saturation.
- Fewer than WIDTH bits: sr holds a partial value. Because capture loads sr from dbgreg_in, the unshifted upper-end bits come from dbgreg_in. The soc uses dbgreg_len to validate the transfer.
- dbgreg_strobe is never high in two consecutive cycles.
- If rst is asserted mid-transaction, everything returns to reset values and the next tck_rise is handled normally.

Decomposition:
- Shared package: DBG_SEL_ER1=0 and DBG_SEL_ER2=1, the default WIDTH, and a localparam for the sync depth.
- Natural sub-module: jtag_sync, a parameterised N-stage synchroniser with a rising-edge detect output. It is instantiated once as a bundle carrying {jtck, jtdi, jshift, jupdate, jce1, jce2, jrstn}.

Test Plan:
- Write path:
  - Stimulus: after rst, TAP reset, capture with jce1, 32 shifts of 0xDEADBEEF LSB first, then update.
  - Required response: dbgreg_out=0xDEADBEEF, dbgreg_sel=0, dbgreg_len=32, one strobe exactly 3 clk cycles after the clk edge that first samples the update-edge jtck high.
- Readback:
  - Stimulus: dbgreg_in=0x12345678, capture with jce2, 32 shifts with jtdi=0.
  - Required response: jtdo2 emits 0x12345678 LSB first, jtdo1 stays 0; after update, dbgreg_out=0, dbgreg_sel=1.
- Short and long shifts:
  - 8-bit shift of 0xA5 after capture of dbgreg_in=0 -> dbgreg_out=0xA5000000, dbgreg_len=8.
  - 40-bit shift -> last 32 bits retained, dbgreg_len=40.
  - 70-bit shift -> dbgreg_len=63 (saturated).
- TAP reset mid-shift: assert jrstn=0 after 10 shifts -> no strobe; dbgreg_out keeps its previous value; a following full 32-bit transaction updates correctly with len=32.
- Simultaneous/priority:
  - jce1 and jce2 high together at capture -> sel=1.
  - jupdate and jshift high together -> update taken, sr not shifted, single strobe.
- System reset: assert rst during shift and while a strobe is pending -> all outputs 0 the next cycle, no strobe emitted; normal operation resumes after rst deasserts.
